// File: rtl/mac_buffer_ctrl.sv
// mac_buffer_ctrl: loads an A|B operand pair into the MAC buffer, then walks the read pairs for a dot product.
// Optional: define MAC_CTRL_PERF_EN to add the perf_cycles output (LOAD+COMPUTE cycle count of the last operation).
module mac_buffer_ctrl #(
    parameter int DataWidth   = 8,
    parameter int BufferSize  = 4,
    parameter int BufferWidth = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [DataWidth-1:0]   in_data,
    output logic                   in_ready,
    output logic                   buf_en,
    output logic [BufferWidth-1:0] buf_waddr,
    output logic [DataWidth-1:0]   buf_din,
    output logic [BufferWidth-1:0] buf_raddr1,
    output logic [BufferWidth-1:0] buf_raddr2,
    output logic                   mac_en,
    output logic                   mac_first,
    output logic                   busy,
`ifdef MAC_CTRL_PERF_EN
    output logic [15:0]            perf_cycles,
`endif
    output logic                   done
);
    localparam int RW = BufferWidth > 1 ? BufferWidth - 1 : 1;
    localparam logic [BufferWidth-1:0] W_LAST = BufferWidth'(BufferSize - 1);
    localparam logic [BufferWidth-1:0] HALF   = BufferWidth'(BufferSize / 2);
    localparam logic [RW-1:0]          R_LAST = RW'(BufferSize / 2 - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

    state_t                 state, state_n;
    logic [BufferWidth-1:0] wcnt, wcnt_n;
    logic [RW-1:0]          rcnt, rcnt_n;

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wcnt  <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            rcnt  <= rcnt_n;
        end
    end

    // Next-state, counter wrap and datapath controls; stream signals pass straight through in LOAD
    always_comb begin
        state_n    = state;
        wcnt_n     = wcnt;
        rcnt_n     = rcnt;
        in_ready   = state == LOAD;
        buf_en     = in_ready & in_valid;
        buf_waddr  = in_ready ? wcnt : '0;
        buf_din    = in_ready ? in_data : '0;
        mac_en     = state == COMPUTE;
        mac_first  = mac_en && rcnt == '0;
        buf_raddr1 = mac_en ? BufferWidth'(rcnt) : '0;
        buf_raddr2 = mac_en ? BufferWidth'(rcnt) + HALF : '0;
        busy       = state != IDLE;
        done       = state == DONE;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                    wcnt_n  = '0;
                end
            end
            LOAD: begin
                if (buf_en) begin
                    wcnt_n = wcnt == W_LAST ? '0 : wcnt + BufferWidth'(1);
                    if (wcnt == W_LAST) begin
                        state_n = COMPUTE;
                        rcnt_n  = '0;
                    end
                end
            end
            COMPUTE: begin
                rcnt_n = rcnt == R_LAST ? '0 : rcnt + RW'(1);
                if (rcnt == R_LAST) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef MAC_CTRL_PERF_EN
    // Cycle counter: cleared on start, counts LOAD/COMPUTE cycles saturating, holds otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_cycles <= '0;
        else if (state == IDLE && start)
            perf_cycles <= '0;
        else if ((state == LOAD || state == COMPUTE) && perf_cycles != 16'hFFFF)
            perf_cycles <= perf_cycles + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mac_buffer_ctrl.sv
// tb_mac_buffer_ctrl: directed self-checking bench for mac_buffer_ctrl with a buffer and MAC model.
module tb_mac_buffer_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, buf_en, mac_en, mac_first, busy, done;
    logic [1:0] buf_waddr, buf_raddr1, buf_raddr2;
    logic [7:0] buf_din;
`ifdef MAC_CTRL_PERF_EN
    logic [15:0] perf_cycles;
`endif
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0]  mem [4];
    logic [31:0] acc = '0;
    logic [19:0] st;

    mac_buffer_ctrl #(.DataWidth(8), .BufferSize(4), .BufferWidth(2)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .buf_en(buf_en), .buf_waddr(buf_waddr), .buf_din(buf_din),
        .buf_raddr1(buf_raddr1), .buf_raddr2(buf_raddr2), .mac_en(mac_en), .mac_first(mac_first),
        .busy(busy),
`ifdef MAC_CTRL_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    assign st = {in_ready, buf_en, buf_waddr, buf_din, buf_raddr1, buf_raddr2, mac_en, mac_first, busy, done};

    // Buffer with one write port and two combinational reads, feeding a load/accumulate MAC
    always @(posedge clk) begin
        if (buf_en) mem[buf_waddr] <= buf_din;
        if (mac_en) acc <= mac_first ? 32'(mem[buf_raddr1]) * 32'(mem[buf_raddr2])
                                     : acc + 32'(mem[buf_raddr1]) * 32'(mem[buf_raddr2]);
    end

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        start = s;
        in_valid = v;
        in_data = d;
        #1;
    endtask

    task automatic run_op(input logic [7:0] a0, a1, b0, b1, input int stall, input bit ign, input logic [31:0] res);
        logic [7:0] w [4];
        w = '{a0, a1, b0, b1};
        cyc(1'b1, 1'b0, 8'h00);
        chk("start_idle_busy", 32'(busy), 0);
        chk("start_idle_ready", 32'(in_ready), 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 2)
                for (int k = 0; k < stall; k++) begin
                    cyc(1'b0, 1'b0, 8'hAA);
                    chk("stall_ready_en", 32'({in_ready, buf_en}), 32'b10);
                    chk("stall_waddr", 32'(buf_waddr), 2);
                end
            cyc(ign && i == 1, 1'b1, w[i]);
            chk("load_ready_en_busy", 32'({in_ready, buf_en, busy}), 32'b111);
            chk("load_waddr", 32'(buf_waddr), 32'(i));
            chk("load_din", 32'(buf_din), 32'(w[i]));
`ifdef MAC_CTRL_PERF_EN
            if (i == 0) chk("perf_zeroed", 32'(perf_cycles), 0);
`endif
        end
        cyc(ign, 1'b0, 8'h00);
        chk("cmp0_en_first", 32'({mac_en, mac_first, in_ready, buf_en}), 32'b1100);
        chk("cmp0_raddr", 32'({buf_raddr1, buf_raddr2}), 32'b0010);
        cyc(1'b0, 1'b0, 8'h00);
        chk("cmp1_en_first", 32'({mac_en, mac_first}), 32'b10);
        chk("cmp1_raddr", 32'({buf_raddr1, buf_raddr2}), 32'b0111);
        cyc(ign, 1'b0, 8'h00);
        chk("done_state", 32'({done, busy, mac_en, buf_raddr1, buf_raddr2}), 32'b1100000);
        chk("mac_result", acc, res);
`ifdef MAC_CTRL_PERF_EN
        chk("perf_at_done", 32'(perf_cycles), 32'(6 + stall));
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", 32'(st), 0);
`ifdef MAC_CTRL_PERF_EN
        chk("reset_perf", 32'(perf_cycles), 0);
`endif
        reset = 1'b0;
        run_op(8'd3, 8'd5, 8'd7, 8'd2, 0, 1'b0, 32'd31);
        cyc(1'b0, 1'b0, 8'h00);
        chk("after_done_idle", 32'(st), 0);
        run_op(8'd3, 8'd5, 8'd7, 8'd2, 3, 1'b0, 32'd31);
        cyc(1'b0, 1'b0, 8'h00);
        chk("after_stall_idle", 32'(st), 0);
`ifdef MAC_CTRL_PERF_EN
        chk("perf_hold", 32'(perf_cycles), 9);
`endif
        run_op(8'd3, 8'd5, 8'd7, 8'd2, 0, 1'b1, 32'd31);
        cyc(1'b0, 1'b0, 8'h00);
        chk("ignored_start_idle", 32'(st), 0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("ignored_start_still_idle", 32'(st), 0);
        chk("done_count_3", 32'(done_cnt), 3);
        run_op(8'd3, 8'd5, 8'd7, 8'd2, 0, 1'b0, 32'd31);
        run_op(8'd1, 8'd2, 8'd3, 8'd4, 0, 1'b0, 32'd11);
        cyc(1'b0, 1'b0, 8'h00);
        chk("after_b2b_idle", 32'(st), 0);
        chk("done_count_5", 32'(done_cnt), 5);
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(i + 9));
        cyc(1'b0, 1'b0, 8'h00);
        chk("pre_reset_compute", 32'({mac_en, busy}), 32'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(st), 0);
`ifdef MAC_CTRL_PERF_EN
        chk("async_reset_perf", 32'(perf_cycles), 0);
`endif
        @(posedge clk);
        #1;
        chk("reset_held_outputs", 32'(st), 0);
        #2;
        reset = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        chk("post_reset_idle", 32'(st), 0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("post_reset_still_idle", 32'(st), 0);
        chk("no_done_after_reset", 32'(done_cnt), 5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_buffer_ctrl.md
Name: mac_buffer_ctrl

Overview:
Sequencer for the MAC operand buffer (1 write port, 2 combinational read ports). It loads a vector pair into the buffer over a valid/ready stream, then issues read-address pairs and MAC enables to form a dot product. Operand A occupies the lower half of the buffer and operand B the upper half. Sits between the input stream and the buffer/MAC datapath.

Parameters:
DataWidth, 8, operand word width; passed through to buf_din.
BufferSize, 4, buffer depth; must equal 2**BufferWidth, even, >=2.
BufferWidth, 2, buffer address width.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin operation; sampled only in IDLE
in_valid  input  1  input word valid
in_data  input  DataWidth  input operand word
in_ready  output  1  controller accepts a word this cycle
buf_en  output  1  buffer write enable
buf_waddr  output  BufferWidth  buffer write address
buf_din  output  DataWidth  buffer write data
buf_raddr1  output  BufferWidth  read address, operand A
buf_raddr2  output  BufferWidth  read address, operand B
mac_en  output  1  MAC consumes the current read pair
mac_first  output  1  with mac_en: MAC loads the product instead of accumulating
busy  output  1  state != IDLE
done  output  1  one-cycle pulse; MAC result is final

Behaviour:
- States: IDLE, LOAD, COMPUTE, DONE. Registers: state, wcnt (BufferWidth), rcnt (BufferWidth-1 bits, min 1).
- Reset (async, any state, including mid-LOAD/COMPUTE): state=IDLE, wcnt=0, rcnt=0. All outputs are 0 while reset is held and in IDLE. The buffer contents are not touched.
- IDLE: start=1 -> LOAD next cycle, with wcnt=0.
- LOAD:
  - in_ready=1.
  - buf_en = in_valid & in_ready; buf_waddr = wcnt; buf_din = in_data. These are combinational from the stream.
  - On each accepted word, wcnt increments.
  - in_valid=0 stalls LOAD indefinitely with no write.
  - Accepting the word at wcnt=BufferSize-1 -> COMPUTE, with rcnt=0 and wcnt wrapping to 0.
- COMPUTE: one pair per cycle, no stalls.
  - mac_en=1; buf_raddr1 = rcnt; buf_raddr2 = rcnt + BufferSize/2.
  - mac_first = (rcnt==0).
  - rcnt increments each cycle.
  - At rcnt = BufferSize/2-1 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Outside their states, in_ready, buf_en, mac_en, mac_first and done are 0. The read addresses hold 0 outside COMPUTE.
- start outside IDLE is ignored. A start in the DONE cycle is also ignored; the earliest restart is the cycle after DONE.
- Latency with a continuous stream, start at cycle 0:
  - LOAD cycles 1..BufferSize.
  - COMPUTE cycles BufferSize+1 .. BufferSize+BufferSize/2.
  - done at BufferSize+BufferSize/2+1.
  - Defaults: LOAD 1-4, COMPUTE 5-6, done at 7.
- Counters never exceed their range. The wrap of wcnt and rcnt is explicit, not reliant on overflow.

Optional Feature:
Macro MAC_CTRL_PERF_EN.
- Defined: adds output perf_cycles [15:0], the number of cycles spent in LOAD+COMPUTE for the last operation.
  - It is zeroed at IDLE->LOAD.
  - It increments in every LOAD/COMPUTE cycle, saturating at 16'hFFFF.
  - It holds its value from DONE until the next start.
  - Async reset clears it to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-COMPUTE: assert reset asynchronously between clock edges -> outputs 0 immediately; IDLE after release; no done pulse.
- Continuous load: start at cycle 0, data 3,5,7,2 with in_valid held high -> writes addr0..3 in cycles 1-4; COMPUTE pairs (0,2) in cycle 5 with mac_first=1 and (1,3) in cycle 6; done at cycle 7; external MAC result 3*7+5*2=31.
- Stalled load: drop in_valid for 3 cycles after the second word -> buf_en=0 and wcnt held during the stall; done arrives 3 cycles later (cycle 10); same addresses and result.
- Ignored start: pulse start during LOAD, COMPUTE and DONE -> no state change; exactly one done pulse; busy falls the cycle after done.
- Back-to-back: start on the cycle after done -> second operation with identical timing; mac_first=1 again on its first COMPUTE cycle.
- MAC_CTRL_PERF_EN built: run the stalled-load case -> perf_cycles=9 at done, holding until the next start; with the macro undefined, the build has no perf_cycles port.
